// File: rtl/interrupt_sequencer_pkg.sv
// Shared types for the interrupt entry sequencer: interrupt sources,
// sequence states, stack push selectors and the registered output bundle.
package interrupt_pkg;

    typedef enum logic [2:0] {
        SRC_NONE  = 3'd0,
        SRC_RESET = 3'd1,
        SRC_NMI   = 3'd2,
        SRC_IRQ   = 3'd3,
        SRC_BRK   = 3'd4
    } src_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_DUMMY1  = 3'd1,
        ST_DUMMY2  = 3'd2,
        ST_STK_PCH = 3'd3,
        ST_STK_PCL = 3'd4,
        ST_STK_P   = 3'd5,
        ST_VEC_LO  = 3'd6,
        ST_VEC_HI  = 3'd7
    } seq_state_t;

    localparam logic [1:0] PUSH_PCH = 2'd0;
    localparam logic [1:0] PUSH_PCL = 2'd1;
    localparam logic [1:0] PUSH_P   = 2'd2;

    typedef struct packed {
        logic        seq_active;
        logic        push_en;
        logic        sp_dec;
        logic [1:0]  push_sel;
        logic        b_flag;
        logic [15:0] vec_addr;
        logic        vec_lo_load;
        logic        vec_hi_load;
        logic        set_i;
        logic        seq_done;
    } seq_out_t;

endpackage

// File: rtl/interrupt_sequencer_if.sv
// Core-side handshake between the 8227 datapath/decoder and the interrupt
// sequencer. master = core, slave = sequencer.
interface interrupt_sequencer_if;
    logic        reset_req;
    logic        instr_done;
    logic        irq_mask;
    logic        brk_req;
    logic        seq_active;
    logic        push_en;
    logic        sp_dec;
    logic [1:0]  push_sel;
    logic        b_flag;
    logic [15:0] vec_addr;
    logic        vec_lo_load;
    logic        vec_hi_load;
    logic        set_i;
    logic        seq_done;

    modport master (
        output reset_req, instr_done, irq_mask, brk_req,
        input  seq_active, push_en, sp_dec, push_sel, b_flag, vec_addr,
               vec_lo_load, vec_hi_load, set_i, seq_done
    );

    modport slave (
        input  reset_req, instr_done, irq_mask, brk_req,
        output seq_active, push_en, sp_dec, push_sel, b_flag, vec_addr,
               vec_lo_load, vec_hi_load, set_i, seq_done
    );
endinterface

// File: rtl/interrupt_sequencer_sync_edge_detect.sv
// Multi-flop synchronizer for an asynchronous input, with the synchronized
// level and a one-cycle pulse on its rising edge.
module sync_edge_detect #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic level,
    output logic rise
);
    logic [STAGES-1:0] sync_q, sync_d;
    logic              prev_q, prev_d;

    // Shift the raw input through the chain and remember the last synced level.
    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
        prev_d = sync_q[STAGES-1];
    end

    // Synchronizer and edge-history flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign level = sync_q[STAGES-1];
    assign rise  = sync_q[STAGES-1] & ~prev_q;
endmodule

// File: rtl/interrupt_sequencer.sv
// Reset/NMI/IRQ/BRK entry sequencer for the 8227 core: picks a source at an
// instruction boundary and runs the 7-cycle dummy/stack/vector sequence.
// Optional build macro: INTERRUPT_SEQUENCER_NMI_HIJACK_EN lets a pending NMI
// take over the vector fetch of an IRQ/BRK sequence already pushing state.
module interrupt_sequencer
    import interrupt_pkg::*;
#(
    parameter logic [15:0] NMI_VECTOR   = 16'hFFFA,
    parameter logic [15:0] RESET_VECTOR = 16'hFFFC,
    parameter logic [15:0] IRQ_VECTOR   = 16'hFFFE,
    parameter int          SYNC_STAGES  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  nmi,
    input  logic                  irq,
    interrupt_sequencer_if.slave  bus
);
    seq_state_t state_q, state_d;
    src_t       src_q, src_d;
    logic       nmi_pending_q, nmi_pending_d;
    logic       reset_pending_q, reset_pending_d;
    seq_out_t   out_q, out_d;
    logic       nmi_level_unused, nmi_rise;
    logic       irq_level, irq_rise_unused;
    logic       irq_take;

    sync_edge_detect #(.STAGES(SYNC_STAGES)) u_nmi_sync (
        .clk(clk), .rst(rst), .d(nmi), .level(nmi_level_unused), .rise(nmi_rise)
    );

    sync_edge_detect #(.STAGES(SYNC_STAGES)) u_irq_sync (
        .clk(clk), .rst(rst), .d(irq), .level(irq_level), .rise(irq_rise_unused)
    );

    // Vector low-byte address for a source; IRQ and BRK share one vector.
    function automatic logic [15:0] vec_base(input src_t s);
        case (s)
            SRC_RESET: vec_base = RESET_VECTOR;
            SRC_NMI:   vec_base = NMI_VECTOR;
            default:   vec_base = IRQ_VECTOR;
        endcase
    endfunction

    assign irq_take = irq_level & ~bus.irq_mask;

    // Next state, latched source and pending-request bookkeeping.
    always_comb begin
        state_d         = state_q;
        src_d           = src_q;
        nmi_pending_d   = nmi_pending_q;
        reset_pending_d = reset_pending_q;
        case (state_q)
            ST_IDLE: begin
                if (reset_pending_q) begin
                    state_d         = ST_DUMMY1;
                    src_d           = SRC_RESET;
                    reset_pending_d = 1'b0;
                end else if (bus.instr_done && (nmi_pending_q || irq_take || bus.brk_req)) begin
                    state_d = ST_DUMMY1;
                    if (nmi_pending_q)  src_d = SRC_NMI;
                    else if (irq_take)  src_d = SRC_IRQ;
                    else                src_d = SRC_BRK;
                end else begin
                    src_d = SRC_NONE;
                end
            end
            ST_DUMMY1:  state_d = ST_DUMMY2;
            ST_DUMMY2:  state_d = ST_STK_PCH;
            ST_STK_PCH: state_d = ST_STK_PCL;
            ST_STK_PCL: state_d = ST_STK_P;
            ST_STK_P: begin
                state_d = ST_VEC_LO;
`ifdef INTERRUPT_SEQUENCER_NMI_HIJACK_EN
                if (nmi_pending_q && (src_q == SRC_IRQ || src_q == SRC_BRK)) src_d = SRC_NMI;
                else                                                        src_d = src_q;
`else
                src_d = src_q;
`endif
            end
            ST_VEC_LO: begin
                state_d = ST_VEC_HI;
                if (src_q == SRC_NMI) nmi_pending_d = 1'b0;
                else                  nmi_pending_d = nmi_pending_q;
            end
            ST_VEC_HI: begin
                state_d = ST_IDLE;
                src_d   = SRC_NONE;
            end
            default: begin
                state_d = ST_IDLE;
                src_d   = SRC_NONE;
            end
        endcase
        // A soft reset request abandons whatever is running.
        if (bus.reset_req) begin
            state_d         = ST_DUMMY1;
            src_d           = SRC_RESET;
            reset_pending_d = 1'b0;
        end else begin
            reset_pending_d = reset_pending_d;
        end
        // A new NMI edge wins over a same-cycle clear.
        if (nmi_rise) nmi_pending_d = 1'b1;
        else          nmi_pending_d = nmi_pending_d;
    end

    // Decode the strobes for the state being entered so outputs come straight from flops.
    always_comb begin
        out_d            = '0;
        out_d.seq_active = (state_d != ST_IDLE);
        case (state_d)
            ST_STK_PCH: begin
                out_d.push_en  = (src_d != SRC_RESET);
                out_d.sp_dec   = 1'b1;
                out_d.push_sel = PUSH_PCH;
            end
            ST_STK_PCL: begin
                out_d.push_en  = (src_d != SRC_RESET);
                out_d.sp_dec   = 1'b1;
                out_d.push_sel = PUSH_PCL;
            end
            ST_STK_P: begin
                out_d.push_en  = (src_d != SRC_RESET);
                out_d.sp_dec   = 1'b1;
                out_d.push_sel = PUSH_P;
                out_d.b_flag   = (src_d == SRC_BRK);
            end
            ST_VEC_LO: begin
                out_d.vec_addr    = vec_base(src_d);
                out_d.vec_lo_load = 1'b1;
                out_d.set_i       = 1'b1;
            end
            ST_VEC_HI: begin
                out_d.vec_addr    = vec_base(src_d) + 16'd1;
                out_d.vec_hi_load = 1'b1;
                out_d.seq_done    = 1'b1;
            end
            default: out_d.vec_addr = 16'h0000;
        endcase
    end

    // State, source, pending flags and registered strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            src_q           <= SRC_NONE;
            nmi_pending_q   <= 1'b0;
            reset_pending_q <= 1'b1;
            out_q           <= '0;
        end else begin
            state_q         <= state_d;
            src_q           <= src_d;
            nmi_pending_q   <= nmi_pending_d;
            reset_pending_q <= reset_pending_d;
            out_q           <= out_d;
        end
    end

    assign bus.seq_active  = out_q.seq_active;
    assign bus.push_en     = out_q.push_en;
    assign bus.sp_dec      = out_q.sp_dec;
    assign bus.push_sel    = out_q.push_sel;
    assign bus.b_flag      = out_q.b_flag;
    assign bus.vec_addr    = out_q.vec_addr;
    assign bus.vec_lo_load = out_q.vec_lo_load;
    assign bus.vec_hi_load = out_q.vec_hi_load;
    assign bus.set_i       = out_q.set_i;
    assign bus.seq_done    = out_q.seq_done;
endmodule
